// File: rtl/pipe_write_checker.sv
// pipe_write_checker: write-throughput test sink for the pipe-in path.
// Pipe words are buffered in a block-RAM FIFO, drained one word per cycle
// into a registered compare stage, and checked against a pattern generator.
// A cycle timer and word/error counters are exported for wire-out readback.
// Optional feature macro: FIRST_ERROR_CAPTURE_EN (latches index and data of
// the first mismatch since reset; without it those ports are tied to 0).
module pipe_write_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2048,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                          okClk,
    input  logic                          reset,
    input  logic                          start_timer,
    input  logic                          stop_timer,
    input  logic                          reset_pattern,
    input  logic [1:0]                    mode,
    input  logic [DATA_WIDTH-1:0]         seed,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          timer_on,
    output logic [CNT_WIDTH-1:0]          clk_counts,
    output logic [31:0]                   word_count,
    output logic [31:0]                   error_count,
    output logic [31:0]                   first_err_index,
    output logic [DATA_WIDTH-1:0]         first_err_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    // FIFO storage and pointers
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           level_q, level_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  push, pop;

    // Read-out and compare stage
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] cmp_data_q, cmp_data_d;
    logic                  cmp_valid_q, cmp_valid_d;

    // Checker state
    logic [DATA_WIDTH-1:0] expected_q, expected_d;
    logic [DATA_WIDTH-1:0] next_pat;
    logic [31:0]           word_count_q, word_count_d;
    logic [31:0]           error_count_q, error_count_d;
    logic                  do_check, mismatch;

    // Timer state
    logic                  timer_on_q, timer_on_d;
    logic [CNT_WIDTH-1:0]  clk_counts_q, clk_counts_d;

    // FIFO bookkeeping: accept when not full, pop whenever anything is stored
    always_comb begin
        push       = wr_en && !full_q;
        pop        = (level_q != '0);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!push && pop) begin
            level_d = level_q - (AW+1)'(1);
        end
        full_d     = (level_d == DEPTH_L);
        overflow_d = overflow_q || (wr_en && full_q);
        rd_valid_d = pop;
        cmp_valid_d = rd_valid_q;
        cmp_data_d  = rd_data_q;
    end

    // Block RAM write port and registered read port (no reset on the data path)
    always_ff @(posedge okClk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (pop) begin
            rd_data_q <= mem[rd_ptr_q];
        end
        cmp_data_q <= cmp_data_d;
    end

    // Pattern generator step for the word being checked; mode is sampled here
    always_comb begin
        case (mode)
            2'd0:    next_pat = seed;
            2'd1:    next_pat = expected_q + DATA_WIDTH'(1);
            2'd2:    next_pat = {expected_q[DATA_WIDTH-2:0], expected_q[DATA_WIDTH-1]};
            default: next_pat = ~expected_q;
        endcase
    end

    // Check stage: a pattern restart discards the word that is in the stage
    always_comb begin
        do_check      = cmp_valid_q && !reset_pattern;
        mismatch      = do_check && (cmp_data_q != expected_q);
        expected_d    = expected_q;
        word_count_d  = word_count_q;
        error_count_d = error_count_q;
        if (reset_pattern) begin
            expected_d   = seed;
            word_count_d = '0;
        end else if (cmp_valid_q) begin
            expected_d   = next_pat;
            word_count_d = word_count_q + 32'd1;
            if (mismatch && (error_count_q != 32'hFFFF_FFFF)) begin
                error_count_d = error_count_q + 32'd1;
            end
        end
    end

    // Cycle timer: stop beats start; start counts its own cycle
    always_comb begin
        timer_on_d   = timer_on_q;
        clk_counts_d = clk_counts_q;
        if (stop_timer) begin
            timer_on_d = 1'b0;
        end else if (start_timer || timer_on_q) begin
            timer_on_d   = 1'b1;
            clk_counts_d = clk_counts_q + CNT_WIDTH'(1);
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge okClk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            overflow_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            cmp_valid_q   <= 1'b0;
            expected_q    <= seed;
            word_count_q  <= '0;
            error_count_q <= '0;
            timer_on_q    <= 1'b0;
            clk_counts_q  <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            full_q        <= full_d;
            overflow_q    <= overflow_d;
            rd_valid_q    <= rd_valid_d;
            cmp_valid_q   <= cmp_valid_d;
            expected_q    <= expected_d;
            word_count_q  <= word_count_d;
            error_count_q <= error_count_d;
            timer_on_q    <= timer_on_d;
            clk_counts_q  <= clk_counts_d;
        end
    end

    assign full        = full_q;
    assign fifo_level  = level_q;
    assign overflow    = overflow_q;
    assign timer_on    = timer_on_q;
    assign clk_counts  = clk_counts_q;
    assign word_count  = word_count_q;
    assign error_count = error_count_q;

`ifdef FIRST_ERROR_CAPTURE_EN
    logic                  err_seen_q, err_seen_d;
    logic [31:0]           fe_index_q, fe_index_d;
    logic [DATA_WIDTH-1:0] fe_data_q, fe_data_d;

    // Latch the first mismatch only; index is the count before this word
    always_comb begin
        err_seen_d = err_seen_q;
        fe_index_d = fe_index_q;
        fe_data_d  = fe_data_q;
        if (mismatch && !err_seen_q) begin
            err_seen_d = 1'b1;
            fe_index_d = word_count_q;
            fe_data_d  = cmp_data_q;
        end
    end

    // First-error capture registers, cleared by reset only
    always_ff @(posedge okClk) begin
        if (reset) begin
            err_seen_q <= 1'b0;
            fe_index_q <= '0;
            fe_data_q  <= '0;
        end else begin
            err_seen_q <= err_seen_d;
            fe_index_q <= fe_index_d;
            fe_data_q  <= fe_data_d;
        end
    end

    assign first_err_index = fe_index_q;
    assign first_err_data  = fe_data_q;
`else
    assign first_err_index = '0;
    assign first_err_data  = '0;
`endif

endmodule
